// File: rtl/legv8_pkg.sv
// Shared LEGv8 datapath definitions: forward selects, the XZR index, ALU op codes
// and the load-use hazard rule used by the ID/EX stage.
package legv8_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_t;

    localparam logic [4:0] XZR = 5'd31;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;
    localparam logic [3:0] ALU_NOR   = 4'b1100;

    // A load in EX whose destination a decoding instruction reads cannot be bypassed in time
    function automatic logic load_use_hazard(
        input logic       valid_d,
        input logic       valid_e,
        input logic       mem_read_e,
        input logic [4:0] rd_e,
        input logic [4:0] rn_d,
        input logic [4:0] rm_d
    );
        return valid_d & valid_e & mem_read_e & (rd_e != XZR) &
               ((rd_e == rn_d) | (rd_e == rm_d));
    endfunction

endpackage

// File: rtl/idex_fwd_stage_if.sv
// Signal bundle between decode, the bypass network and the ID/EX stage.
// master = environment driving decode/bypass, slave = the ID/EX stage.
interface idex_fwd_stage_if #(parameter int N = 64);

    logic         valid_D;
    logic [N-1:0] readData1_D;
    logic [N-1:0] readData2_D;
    logic [N-1:0] signImm_D;
    logic [4:0]   rn_D;
    logic [4:0]   rm_D;
    logic [4:0]   rd_D;
    logic         ALUSrc_D;
    logic [3:0]   ALUControl_D;
    logic         regWrite_D;
    logic         memRead_D;
    logic         memWrite_D;
    logic         memtoReg_D;
    logic         branch_D;
    logic         stall;
    logic         flush;
    logic [4:0]   rd_M;
    logic         regWrite_M;
    logic [N-1:0] aluResult_M;
    logic [4:0]   rd_W;
    logic         regWrite_W;
    logic [N-1:0] result_W;

    logic [N-1:0] a_E;
    logic [N-1:0] b_E;
    logic [3:0]   ALUControl_E;
    logic [N-1:0] writeData_E;
    logic [4:0]   rd_E;
    logic         valid_E;
    logic         regWrite_E;
    logic         memRead_E;
    logic         memWrite_E;
    logic         memtoReg_E;
    logic         branch_E;
    logic         hazard_stall;
    logic [1:0]   fwdA_sel;
    logic [1:0]   fwdB_sel;

    modport master (
        output valid_D, readData1_D, readData2_D, signImm_D, rn_D, rm_D, rd_D,
               ALUSrc_D, ALUControl_D, regWrite_D, memRead_D, memWrite_D,
               memtoReg_D, branch_D, stall, flush,
               rd_M, regWrite_M, aluResult_M, rd_W, regWrite_W, result_W,
        input  a_E, b_E, ALUControl_E, writeData_E, rd_E, valid_E, regWrite_E,
               memRead_E, memWrite_E, memtoReg_E, branch_E, hazard_stall,
               fwdA_sel, fwdB_sel
    );

    modport slave (
        input  valid_D, readData1_D, readData2_D, signImm_D, rn_D, rm_D, rd_D,
               ALUSrc_D, ALUControl_D, regWrite_D, memRead_D, memWrite_D,
               memtoReg_D, branch_D, stall, flush,
               rd_M, regWrite_M, aluResult_M, rd_W, regWrite_W, result_W,
        output a_E, b_E, ALUControl_E, writeData_E, rd_E, valid_E, regWrite_E,
               memRead_E, memWrite_E, memtoReg_E, branch_E, hazard_stall,
               fwdA_sel, fwdB_sel
    );

endinterface

// File: rtl/fwd_mux.sv
// Operand bypass selector: picks the youngest in-flight result targeting src,
// otherwise passes the registered read value. XZR is never bypassed.
module fwd_mux
    import legv8_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         en,
    input  logic [4:0]   src,
    input  logic [N-1:0] reg_val,
    input  logic         regWrite_M,
    input  logic [4:0]   rd_M,
    input  logic [N-1:0] aluResult_M,
    input  logic         regWrite_W,
    input  logic [4:0]   rd_W,
    input  logic [N-1:0] result_W,
    output fwd_sel_t     sel,
    output logic [N-1:0] val
);

    logic hit_m_s;
    logic hit_w_s;

    assign hit_m_s = en & regWrite_M & (rd_M == src) & (src != XZR);
    assign hit_w_s = en & regWrite_W & (rd_W == src) & (src != XZR);

    // EX/MEM holds the younger result, so it outranks MEM/WB on a double hit
    always_comb begin
        sel = FWD_NONE;
        val = reg_val;
        if (hit_m_s) begin
            sel = FWD_MEM;
            val = aluResult_M;
        end else if (hit_w_s) begin
            sel = FWD_WB;
            val = result_W;
        end else begin
            sel = FWD_NONE;
            val = reg_val;
        end
    end

endmodule

// File: rtl/idex_fwd_stage.sv
// ID/EX pipeline register with load-use bubbling, stall/flush and operand bypass.
// Bypassing is enabled by defining IDEX_FORWARD_EN; otherwise operands come straight from the register.
module idex_fwd_stage
    import legv8_pkg::*;
#(
    parameter int N = 64
) (
    input  logic              clk,
    input  logic              reset,
    idex_fwd_stage_if.slave   bus
);

`ifdef IDEX_FORWARD_EN
    localparam logic FWD_ON = 1'b1;
`else
    localparam logic FWD_ON = 1'b0;
`endif

    typedef struct packed {
        logic         valid;
        logic [4:0]   rn;
        logic [4:0]   rm;
        logic [4:0]   rd;
        logic [N-1:0] rd1;
        logic [N-1:0] rd2;
        logic [N-1:0] imm;
        logic         alu_src;
        logic [3:0]   alu_ctl;
        logic         reg_write;
        logic         mem_read;
        logic         mem_write;
        logic         mem_to_reg;
        logic         branch;
    } idex_regs_t;

    idex_regs_t   cur_r;
    idex_regs_t   nxt_s;
    idex_regs_t   cap_s;
    logic         hazard_s;
    logic         fwd_en_s;
    fwd_sel_t     sel_a_s;
    fwd_sel_t     sel_b_s;
    logic [N-1:0] fwd_a_s;
    logic [N-1:0] fwd_b_s;

    assign hazard_s = load_use_hazard(bus.valid_D, cur_r.valid, cur_r.mem_read,
                                      cur_r.rd, bus.rn_D, bus.rm_D);

    // Decode fields as they would be captured on a normal load
    always_comb begin
        cap_s            = '0;
        cap_s.valid      = bus.valid_D;
        cap_s.rn         = bus.rn_D;
        cap_s.rm         = bus.rm_D;
        cap_s.rd         = bus.rd_D;
        cap_s.rd1        = bus.readData1_D;
        cap_s.rd2        = bus.readData2_D;
        cap_s.imm        = bus.signImm_D;
        cap_s.alu_src    = bus.ALUSrc_D;
        cap_s.alu_ctl    = bus.ALUControl_D;
        cap_s.reg_write  = bus.regWrite_D;
        cap_s.mem_read   = bus.memRead_D;
        cap_s.mem_write  = bus.memWrite_D;
        cap_s.mem_to_reg = bus.memtoReg_D;
        cap_s.branch     = bus.branch_D;
    end

    // Update priority below reset: flush > stall > load-use bubble > load
    always_comb begin
        nxt_s = cur_r;
        if (bus.flush) begin
            nxt_s = '0;
        end else if (bus.stall) begin
            nxt_s = cur_r;
        end else if (hazard_s) begin
            nxt_s = '0;
        end else begin
            nxt_s = cap_s;
        end
    end

    // Stage register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_r <= '0;
        end else begin
            cur_r <= nxt_s;
        end
    end

    // With bypassing disabled both muxes see en=0 and reduce to the registered values
    assign fwd_en_s = FWD_ON & cur_r.valid;

    fwd_mux #(.N(N)) u_fwd_a (
        .en          (fwd_en_s),
        .src         (cur_r.rn),
        .reg_val     (cur_r.rd1),
        .regWrite_M  (bus.regWrite_M),
        .rd_M        (bus.rd_M),
        .aluResult_M (bus.aluResult_M),
        .regWrite_W  (bus.regWrite_W),
        .rd_W        (bus.rd_W),
        .result_W    (bus.result_W),
        .sel         (sel_a_s),
        .val         (fwd_a_s)
    );

    fwd_mux #(.N(N)) u_fwd_b (
        .en          (fwd_en_s),
        .src         (cur_r.rm),
        .reg_val     (cur_r.rd2),
        .regWrite_M  (bus.regWrite_M),
        .rd_M        (bus.rd_M),
        .aluResult_M (bus.aluResult_M),
        .regWrite_W  (bus.regWrite_W),
        .rd_W        (bus.rd_W),
        .result_W    (bus.result_W),
        .sel         (sel_b_s),
        .val         (fwd_b_s)
    );

    assign bus.a_E          = fwd_a_s;
    assign bus.writeData_E  = fwd_b_s;
    assign bus.b_E          = cur_r.alu_src ? cur_r.imm : fwd_b_s;
    assign bus.ALUControl_E = cur_r.alu_ctl;
    assign bus.rd_E         = cur_r.rd;
    assign bus.valid_E      = cur_r.valid;
    assign bus.regWrite_E   = cur_r.reg_write;
    assign bus.memRead_E    = cur_r.mem_read;
    assign bus.memWrite_E   = cur_r.mem_write;
    assign bus.memtoReg_E   = cur_r.mem_to_reg;
    assign bus.branch_E     = cur_r.branch;
    assign bus.hazard_stall = hazard_s;
    assign bus.fwdA_sel     = sel_a_s;
    assign bus.fwdB_sel     = sel_b_s;

endmodule

// File: tb/tb_idex_fwd_stage.sv
// Self-checking bench for idex_fwd_stage: directed scenarios plus a randomized run
// against a behavioural model of the ID/EX stage (follows IDEX_FORWARD_EN).
module tb_idex_fwd_stage;
    import legv8_pkg::*;

    localparam int N = 64;
`ifdef IDEX_FORWARD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    idex_fwd_stage_if #(.N(N)) bus ();
    idex_fwd_stage #(.N(N)) dut (.clk(clk), .reset(reset), .bus(bus));

    // Behavioural model of the execute-stage view
    logic         m_valid, m_alusrc, m_regw, m_memr, m_memw, m_mtr, m_br;
    logic [4:0]   m_rn, m_rm, m_rd;
    logic [N-1:0] m_rd1, m_rd2, m_imm;
    logic [3:0]   m_ctl;

    task automatic model_clear();
        {m_valid, m_alusrc, m_regw, m_memr, m_memw, m_mtr, m_br} = 7'd0;
        {m_rn, m_rm, m_rd} = 15'd0;
        m_rd1 = '0; m_rd2 = '0; m_imm = '0; m_ctl = 4'd0;
    endtask

    function automatic logic exp_hazard();
        return bus.valid_D && m_valid && m_memr && (m_rd != 5'd31) &&
               (m_rd == bus.rn_D || m_rd == bus.rm_D);
    endfunction

    function automatic logic [1:0] exp_sel(input logic [4:0] src);
        if (!FWD_ON || !m_valid || src == 5'd31) return 2'b00;
        if (bus.regWrite_M && bus.rd_M == src) return 2'b10;
        if (bus.regWrite_W && bus.rd_W == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [N-1:0] exp_val(input logic [4:0] src, input logic [N-1:0] regv);
        if (!FWD_ON || !m_valid || src == 5'd31) return regv;
        if (bus.regWrite_M && bus.rd_M == src) return bus.aluResult_M;
        if (bus.regWrite_W && bus.rd_W == src) return bus.result_W;
        return regv;
    endfunction

    // One rising edge; the model applies reset > flush > stall > bubble > load
    task automatic tick();
        logic h;
        h = exp_hazard();
        @(posedge clk);
        if (reset || bus.flush || (!bus.stall && h)) begin
            model_clear();
        end else if (!bus.stall) begin
            m_valid = bus.valid_D;  m_rn = bus.rn_D;  m_rm = bus.rm_D;  m_rd = bus.rd_D;
            m_rd1 = bus.readData1_D; m_rd2 = bus.readData2_D; m_imm = bus.signImm_D;
            m_alusrc = bus.ALUSrc_D; m_ctl = bus.ALUControl_D; m_regw = bus.regWrite_D;
            m_memr = bus.memRead_D; m_memw = bus.memWrite_D; m_mtr = bus.memtoReg_D;
            m_br = bus.branch_D;
        end
        #1;
    endtask

    function automatic logic [4:0] rand_idx();
        int r;
        r = $urandom_range(0, 7);
        return (r == 7) ? 5'd31 : 5'(r);
    endfunction

    function automatic logic [N-1:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic set_decode(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                              input logic [4:0] rd, input logic [N-1:0] d1, input logic [N-1:0] d2,
                              input logic [N-1:0] imm, input logic src, input logic [3:0] ctl,
                              input logic rw, input logic mr);
        bus.valid_D = v; bus.rn_D = rn; bus.rm_D = rm; bus.rd_D = rd;
        bus.readData1_D = d1; bus.readData2_D = d2; bus.signImm_D = imm;
        bus.ALUSrc_D = src; bus.ALUControl_D = ctl; bus.regWrite_D = rw;
        bus.memRead_D = mr; bus.memWrite_D = 1'b0; bus.memtoReg_D = mr; bus.branch_D = 1'b0;
    endtask

    task automatic idle();
        reset = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
        bus.regWrite_M = 1'b0; bus.rd_M = 5'd0; bus.aluResult_M = '0;
        bus.regWrite_W = 1'b0; bus.rd_W = 5'd0; bus.result_W = '0;
        set_decode(1'b0, 5'd0, 5'd0, 5'd0, '0, '0, '0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic rand_inputs();
        set_decode(1'($urandom), rand_idx(), rand_idx(), rand_idx(), rand64(), rand64(),
                   rand64(), 1'($urandom), 4'($urandom), 1'($urandom),
                   ($urandom_range(0, 9) < 3));
        bus.memWrite_D = 1'($urandom); bus.branch_D = 1'($urandom);
        bus.memtoReg_D = 1'($urandom);
        bus.regWrite_M = 1'($urandom); bus.rd_M = rand_idx(); bus.aluResult_M = rand64();
        bus.regWrite_W = 1'($urandom); bus.rd_W = rand_idx(); bus.result_W = rand64();
        bus.stall = ($urandom_range(0, 9) < 2);
        bus.flush = ($urandom_range(0, 9) < 1);
    endtask

    task automatic test_reset();
        rand_inputs(); reset = 1'b1; tick();
        rand_inputs(); tick();
        n_tests++; if (bus.valid_E !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b exp=0", bus.valid_E); end
        n_tests++; if (bus.a_E !== '0) begin n_fail++; $display("FAIL reset_a got=%h exp=0", bus.a_E); end
        n_tests++; if (bus.b_E !== '0) begin n_fail++; $display("FAIL reset_b got=%h exp=0", bus.b_E); end
        n_tests++; if (bus.hazard_stall !== 1'b0) begin n_fail++; $display("FAIL reset_hazard got=%0b exp=0", bus.hazard_stall); end
        n_tests++; if ({bus.fwdA_sel, bus.fwdB_sel} !== 4'b0000) begin n_fail++; $display("FAIL reset_sel got=%b exp=0000", {bus.fwdA_sel, bus.fwdB_sel}); end
        n_tests++; if ({bus.regWrite_E, bus.memRead_E, bus.memWrite_E, bus.memtoReg_E, bus.branch_E, bus.ALUControl_E, bus.rd_E} !== 14'd0) begin
            n_fail++; $display("FAIL reset_ctrl got=%b exp=0", {bus.regWrite_E, bus.memRead_E, bus.memWrite_E, bus.memtoReg_E, bus.branch_E, bus.ALUControl_E, bus.rd_E}); end
        n_tests++; if (bus.writeData_E !== '0) begin n_fail++; $display("FAIL reset_wdata got=%h exp=0", bus.writeData_E); end
        reset = 1'b0;
    endtask

    task automatic test_ex_mem_fwd();
        idle();
        set_decode(1'b1, 5'd1, 5'd2, 5'd4, 64'd5, 64'd7, rand64(), 1'b0, ALU_ADD, 1'b1, 1'b0);
        bus.regWrite_M = 1'b1; bus.rd_M = 5'd1; bus.aluResult_M = 64'd100;
        tick();
        n_tests++; if (bus.a_E !== (FWD_ON ? 64'd100 : 64'd5)) begin n_fail++; $display("FAIL exmem_a got=%0d exp=%0d", bus.a_E, FWD_ON ? 100 : 5); end
        n_tests++; if (bus.b_E !== 64'd7) begin n_fail++; $display("FAIL exmem_b got=%0d exp=7", bus.b_E); end
        n_tests++; if (bus.fwdA_sel !== (FWD_ON ? 2'b10 : 2'b00)) begin n_fail++; $display("FAIL exmem_selA got=%b", bus.fwdA_sel); end
        n_tests++; if (bus.ALUControl_E !== ALU_ADD || bus.valid_E !== 1'b1) begin n_fail++; $display("FAIL exmem_ctl got=%b/%b exp=0010/1", bus.ALUControl_E, bus.valid_E); end
    endtask

    task automatic test_priority_xzr();
        idle();
        set_decode(1'b1, 5'd3, 5'd2, 5'd4, 64'd1, 64'd7, rand64(), 1'b0, ALU_ORR, 1'b1, 1'b0);
        bus.regWrite_M = 1'b1; bus.rd_M = 5'd2; bus.aluResult_M = 64'd11;
        bus.regWrite_W = 1'b1; bus.rd_W = 5'd2; bus.result_W = 64'd22;
        tick();
        n_tests++; if (bus.b_E !== (FWD_ON ? 64'd11 : 64'd7)) begin n_fail++; $display("FAIL prio_b got=%0d exp=%0d", bus.b_E, FWD_ON ? 11 : 7); end
        n_tests++; if (bus.fwdB_sel !== (FWD_ON ? 2'b10 : 2'b00) || bus.fwdA_sel !== 2'b00) begin n_fail++; $display("FAIL prio_sel got=%b/%b", bus.fwdA_sel, bus.fwdB_sel); end
        set_decode(1'b1, 5'd3, 5'd31, 5'd4, 64'd1, 64'd33, rand64(), 1'b0, ALU_ORR, 1'b1, 1'b0);
        bus.rd_M = 5'd31; bus.rd_W = 5'd31;
        tick();
        n_tests++; if (bus.b_E !== 64'd33 || bus.writeData_E !== 64'd33) begin n_fail++; $display("FAIL xzr_b got=%0d/%0d exp=33", bus.b_E, bus.writeData_E); end
        n_tests++; if (bus.fwdB_sel !== 2'b00) begin n_fail++; $display("FAIL xzr_sel got=%b exp=00", bus.fwdB_sel); end
    endtask

    task automatic test_load_use();
        idle();
        set_decode(1'b1, 5'd5, 5'd6, 5'd3, rand64(), rand64(), rand64(), 1'b1, ALU_ADD, 1'b1, 1'b1);
        tick();
        set_decode(1'b1, 5'd3, 5'd7, 5'd8, rand64(), rand64(), rand64(), 1'b0, ALU_SUB, 1'b1, 1'b0);
        #1;
        n_tests++; if (bus.hazard_stall !== 1'b1) begin n_fail++; $display("FAIL lu_hazard got=%0b exp=1", bus.hazard_stall); end
        bus.stall = 1'b1;
        tick();
        n_tests++; if (bus.hazard_stall !== 1'b1 || bus.valid_E !== 1'b1) begin n_fail++; $display("FAIL lu_stall got=%0b/%0b exp=1/1", bus.hazard_stall, bus.valid_E); end
        bus.stall = 1'b0;
        tick();
        n_tests++; if (bus.valid_E !== 1'b0 || {bus.regWrite_E, bus.memRead_E, bus.memtoReg_E} !== 3'b000) begin
            n_fail++; $display("FAIL lu_bubble got=%0b/%b exp=0/000", bus.valid_E, {bus.regWrite_E, bus.memRead_E, bus.memtoReg_E}); end
        n_tests++; if (bus.rd_E !== 5'd0 || bus.hazard_stall !== 1'b0) begin n_fail++; $display("FAIL lu_after got=%0d/%0b exp=0/0", bus.rd_E, bus.hazard_stall); end
    endtask

    task automatic test_stall_flush();
        idle();
        set_decode(1'b1, 5'd10, 5'd11, 5'd12, 64'h55, 64'h66, rand64(), 1'b0, ALU_SUB, 1'b1, 1'b0);
        tick();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_decode(1'b1, rand_idx(), rand_idx(), rand_idx(), rand64(), rand64(), rand64(), 1'b1, ALU_NOR, 1'b0, 1'b0);
            tick();
            n_tests++; if (bus.ALUControl_E !== ALU_SUB || bus.a_E !== 64'h55 || bus.b_E !== 64'h66 || bus.rd_E !== 5'd12) begin
                n_fail++; $display("FAIL stall_hold%0d got=%b/%h/%h/%0d", i, bus.ALUControl_E, bus.a_E, bus.b_E, bus.rd_E); end
        end
        bus.flush = 1'b1;
        tick();
        n_tests++; if (bus.valid_E !== 1'b0 || bus.regWrite_E !== 1'b0 || bus.ALUControl_E !== 4'd0) begin
            n_fail++; $display("FAIL flush_in_stall got=%0b/%0b/%b exp=0/0/0000", bus.valid_E, bus.regWrite_E, bus.ALUControl_E); end
        bus.flush = 1'b0; bus.stall = 1'b0;
    endtask

    task automatic test_imm();
        idle();
        set_decode(1'b1, 5'd1, 5'd5, 5'd2, 64'd3, 64'd1, -64'sd4, 1'b1, ALU_ADD, 1'b1, 1'b0);
        bus.regWrite_M = 1'b1; bus.rd_M = 5'd5; bus.aluResult_M = 64'd9;
        tick();
        n_tests++; if (bus.b_E !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL imm_b got=%h exp=fffffffffffffffc", bus.b_E); end
        n_tests++; if (bus.writeData_E !== (FWD_ON ? 64'd9 : 64'd1)) begin n_fail++; $display("FAIL imm_wdata got=%0d exp=%0d", bus.writeData_E, FWD_ON ? 9 : 1); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            reset = ($urandom_range(0, 29) == 0);
            #1;
            n_tests++; if (bus.hazard_stall !== exp_hazard()) begin n_fail++; $display("FAIL rnd_hazard[%0d] got=%0b exp=%0b", i, bus.hazard_stall, exp_hazard()); end
            n_tests++; if (bus.a_E !== exp_val(m_rn, m_rd1)) begin n_fail++; $display("FAIL rnd_a[%0d] got=%h exp=%h", i, bus.a_E, exp_val(m_rn, m_rd1)); end
            n_tests++; if (bus.writeData_E !== exp_val(m_rm, m_rd2)) begin n_fail++; $display("FAIL rnd_wdata[%0d] got=%h exp=%h", i, bus.writeData_E, exp_val(m_rm, m_rd2)); end
            n_tests++; if (bus.b_E !== (m_alusrc ? m_imm : exp_val(m_rm, m_rd2))) begin n_fail++; $display("FAIL rnd_b[%0d] got=%h", i, bus.b_E); end
            n_tests++; if ({bus.fwdA_sel, bus.fwdB_sel} !== {exp_sel(m_rn), exp_sel(m_rm)}) begin
                n_fail++; $display("FAIL rnd_sel[%0d] got=%b exp=%b", i, {bus.fwdA_sel, bus.fwdB_sel}, {exp_sel(m_rn), exp_sel(m_rm)}); end
            n_tests++; if ({bus.valid_E, bus.regWrite_E, bus.memRead_E, bus.memWrite_E, bus.memtoReg_E, bus.branch_E, bus.ALUControl_E, bus.rd_E} !==
                           {m_valid, m_regw, m_memr, m_memw, m_mtr, m_br, m_ctl, m_rd}) begin
                n_fail++; $display("FAIL rnd_ctrl[%0d] got=%b exp=%b", i,
                    {bus.valid_E, bus.regWrite_E, bus.memRead_E, bus.memWrite_E, bus.memtoReg_E, bus.branch_E, bus.ALUControl_E, bus.rd_E},
                    {m_valid, m_regw, m_memr, m_memw, m_mtr, m_br, m_ctl, m_rd}); end
            tick();
        end
    endtask

    initial begin
        idle();
        model_clear();
        test_reset();
        test_ex_mem_fwd();
        test_priority_xzr();
        test_load_use();
        test_stall_flush();
        test_imm();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/idex_fwd_stage.md
# idex_fwd_stage

ID/EX pipeline register for the pipelined LEGv8 datapath. It sits directly upstream of the execute-stage ALU and drives the ALU's `a`, `b` and `ALUControl` inputs. It latches decoded operands and control, forwards results from EX/MEM and MEM/WB into the operands, detects load-use hazards, and supports stall and flush. All decode-to-ALU hazard handling for the execute stage is confined to this block.

## Interface
- `N`, 64, datapath width (matches ALU `N`)
- `clk` input 1, single clock, rising edge
- `reset` input 1, synchronous, active-high
- `valid_D` input 1, decode stage holds a real instruction
- `readData1_D`, `readData2_D` input N, register-file operands
- `signImm_D` input N, sign-extended immediate
- `rn_D`, `rm_D`, `rd_D` input 5, source and destination register indices
- `ALUSrc_D` input 1, 1 selects the immediate for `b`
- `ALUControl_D` input 4, ALU op code
- `regWrite_D`, `memRead_D`, `memWrite_D`, `memtoReg_D`, `branch_D` input 1 each, control bits
- `stall` input 1, downstream hold
- `flush` input 1, squash the stage (taken branch)
- `rd_M` input 5, `regWrite_M` input 1, `aluResult_M` input N, EX/MEM bypass source
- `rd_W` input 5, `regWrite_W` input 1, `result_W` input N, MEM/WB bypass source
- `a_E`, `b_E` output N, ALU operands
- `ALUControl_E` output 4, ALU op code
- `writeData_E` output N, forwarded rm value for store data
- `rd_E` output 5, `valid_E` output 1, plus registered `regWrite_E`, `memRead_E`, `memWrite_E`, `memtoReg_E`, `branch_E`
- `hazard_stall` output 1, request to IF/ID to hold (load-use)
- `fwdA_sel`, `fwdB_sel` output 2, current forward selects (observability)

## Operation
- Register update on each rising `clk`, priority reset > flush > stall > load-use bubble > load.
- `reset`: all registered fields, including `valid_E` and every control bit, clear to 0.
- `flush`: `valid_E` and all control bits clear to 0, and data and index fields clear to 0.
- `stall` (without flush): all registers hold.
- Load-use bubble applies when `hazard_stall`=1 and `stall`=0. The block loads a bubble (same clear as flush) and does not capture decode.
- Load: capture all `_D` fields, with `valid_E`=`valid_D`.
- `hazard_stall` = `valid_D & valid_E & memRead_E & rd_E!=31 & (rd_E==rn_D | rd_E==rm_D)`. It is combinational and stays asserted during `stall`.
- Forward select, per operand (src = `rn_E` for A, `rm_E` for B), in priority order:
  - `FWD_MEM`(2'b10) if `regWrite_M & rd_M==src & src!=31`
  - otherwise `FWD_WB`(2'b01) if `regWrite_W & rd_W==src & src!=31`
  - otherwise `FWD_NONE`(2'b00)
- Both selects are forced to `FWD_NONE` when `valid_E`=0.
- `a_E` = forwarded rn value.
- `writeData_E` = forwarded rm value.
- `b_E` = `ALUSrc_E` ? `signImm_E` : forwarded rm value.
- X31 (XZR) never forwards. Its registered read value passes through unchanged.

## Timing
- Decode inputs appear on the outputs 1 cycle after the capturing edge.
- Forward muxes, `hazard_stall` and the `fwd*_sel` outputs are combinational; there are no extra cycles.
- After reset, all outputs are 0, with `a_E`=`b_E`=0 and both selects `FWD_NONE`.
- Reset or flush asserted mid-stall still clears on the next edge.
- Simultaneous EX/MEM and MEM/WB hits on the same register: the EX/MEM value wins.

## Configuration
- `IDEX_FORWARD_EN` defined: forwarding as specified above.
- Not defined:
  - The `fwd*_sel` outputs are constant `FWD_NONE`.
  - The bypass inputs are ignored.
  - `a_E`/`writeData_E` come from the registered read data.
  - Load-use detection and bubbling remain active.

## Structure
- Shared package `legv8_pkg`:
  - `fwd_sel_t` enum (`FWD_NONE`, `FWD_WB`, `FWD_MEM`)
  - `XZR` = 5'd31
  - ALU op constants (AND 0000, ORR 0001, ADD 0010, SUB 0110, PASSB 0111, NOR 1100)
- Sub-module `fwd_mux`: compares the source index against the bypass sources, produces the select and the forwarded value. It is combinational and instantiated twice (rn and rm).

## Test plan
- Reset: hold `reset` 2 cycles with random `_D` inputs -> all outputs 0, `valid_E`=0, `hazard_stall`=0.
- EX/MEM forward: load ADD (`rn`=1, `rm`=2), `readData1`=5, `readData2`=7, with `regWrite_M`=1, `rd_M`=1, `aluResult_M`=100 -> `a_E`=100, `b_E`=7, `fwdA_sel`=2'b10.
- Priority and XZR:
  - `rd_M`=`rd_W`=2, values 11 and 22 -> `b_E`=11.
  - `rm`=31 with `rd_M`=31 -> no forward, `b_E`=`readData2`.
- Load-use: `valid_E`, `memRead_E`, `rd_E`=3, then decode `rn_D`=3 -> `hazard_stall`=1; the next edge gives `valid_E`=0 with all controls 0.
- Stall vs flush: load SUB with `stall`=1 for 3 cycles -> outputs unchanged. Then assert `stall`=1 and `flush`=1 together -> `valid_E`=0 and `regWrite_E`=0 next cycle.
- Immediate path: `ALUSrc_D`=1, `signImm`=-4, `rm` forwarded 9 -> `b_E`=-4 and `writeData_E`=9.
